// File: rtl/ksa_multiword_seq.sv
// Multi-cycle wide adder: one 4-bit Kogge-Stone slice per cycle, LSB slice first.
// Define KSA_SEQ_SUB_EN to add a 'sub' port that computes a - b instead of a + b + cin.
module ksa_multiword_seq #(
  parameter int NW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4*NW-1:0] a,
  input  logic [4*NW-1:0] b,
  input  logic            cin,
`ifdef KSA_SEQ_SUB_EN
  input  logic            sub,
`endif
  output logic            busy,
  output logic            done,
  output logic [4*NW-1:0] sum,
  output logic            cout
);

  localparam int W  = 4 * NW;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    shadow_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic [IW+1:0]   slice_lsb;
  logic [4:0]      slice_res;

  // 4-bit Kogge-Stone slice; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] ksa4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic       g0, g1_1, g1_2, g1_3, p1_2, p1_3;
    logic [4:1] c;
    g    = x & y;
    p    = x ^ y;
    g0   = g[0] | (p[0] & ci);
    g1_1 = g[1] | (p[1] & g0);
    g1_2 = g[2] | (p[2] & g[1]);
    g1_3 = g[3] | (p[3] & g[2]);
    p1_2 = p[2] & p[1];
    p1_3 = p[3] & p[2];
    c[1] = g0;
    c[2] = g1_1;
    c[3] = g1_2 | (p1_2 & g0);
    c[4] = g1_3 | (p1_3 & g1_1);
    return {c[4], p ^ {c[3:1], ci}};
  endfunction

  // NOTE: combinational logic gets every output assigned up front so no latch can be inferred.
  always_comb begin
    slice_lsb = {idx_q, 2'b00};
    slice_res = ksa4(a_q[slice_lsb +: 4], b_q[slice_lsb +: 4], carry_q);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and shadow registers are reset too, so an aborted run leaves no stale data.
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef KSA_SEQ_SUB_EN
            // Subtract as a + ~b + 1; cin is ignored in that mode.
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          shadow_q[slice_lsb +: 4] <= slice_res[3:0];
          carry_q                  <= slice_res[4];
          if (idx_q == LAST_IDX) begin
            // Publish the whole result at once; sum never shows a partial value.
            sum_q   <= {slice_res[3:0], shadow_q[W-5:0]};
            cout_q  <= slice_res[4];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Self-checking bench for ksa_multiword_seq (NW=4): directed table, reset abort,
// ignored mid-run start, back-to-back requests and random operands against an arithmetic model.
module tb_ksa_multiword_seq;

  localparam int NW = 4;
  localparam int W  = 4 * NW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef KSA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  ksa_multiword_seq #(.NW(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef KSA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;
    int           gap;
    int           noise_k;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input logic sb, output logic [W-1:0] s, output logic co);
    logic [W:0] r;
    if (sb) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    r = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
    {co, s} = r;
  endtask

  // Idle cycles: nothing running, result held.
  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, " idle busy"}, busy, 0);
      check({name, " idle done"}, done, 0);
      check({name, " idle sum"}, sum, held_sum);
      check({name, " idle cout"}, cout, held_cout);
    end
  endtask

  // Called at a negedge; launches a request and returns at the negedge of its done cycle.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                    input logic sb, input logic [W-1:0] es, input logic ec,
                    input int noise_k, input string name);
    start = 1'b1; a = av; b = bv; cin = ci;
`ifdef KSA_SEQ_SUB_EN
    sub = sb;
`endif
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef KSA_SEQ_SUB_EN
    sub = 1'($urandom);
`endif
    for (int k = 1; k <= NW + 1; k++) begin
      check({name, " busy"}, busy, (k <= NW) ? 1 : 0);
      check({name, " done"}, done, (k == NW + 1) ? 1 : 0);
      if (k <= NW) begin
        check({name, " sum held"}, sum, held_sum);
        check({name, " cout held"}, cout, held_cout);
      end else begin
        check({name, " sum"}, sum, es);
        check({name, " cout"}, cout, ec);
        held_sum  = es;
        held_cout = ec;
      end
      if (k == noise_k) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k <= NW) @(negedge clk);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1, 0, 16'h5555, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 0, 0, 16'h0010, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b1, 1, 0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 2, 2, 16'h0000, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 0, 3, 16'h0000, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b1, 1, 1, 16'h8001, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 2, 4, 16'hBCDF, 1'b0};
    vecs[7] = '{16'h0FF0, 16'h00F0, 1'b0, 1, 0, 16'h10E0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef KSA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    held_sum = '0; held_cout = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      idle(vecs[i].gap, $sformatf("vec%0d", i));
      op(vecs[i].av, vecs[i].bv, vecs[i].ci, 1'b0, vecs[i].es, vecs[i].ec,
         vecs[i].noise_k, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a run aborts it immediately and suppresses done.
    idle(1, "abort");
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    held_sum = '0; held_cout = 1'b0;
    idle(NW + 2, "after abort");
    op(16'h2468, 16'h1357, 1'b1, 1'b0, 16'h37C0, 1'b0, 0, "after abort op");

`ifdef KSA_SEQ_SUB_EN
    idle(1, "sub");
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, "sub 5-7");
    idle(1, "sub");
    op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0, "sub 7-5");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] av, bv, es;
      logic         ci, sb, ec;
      av = W'($urandom); bv = W'($urandom); ci = 1'($urandom);
      sb = 1'b0;
`ifdef KSA_SEQ_SUB_EN
      sb = 1'($urandom);
`endif
      if (i % 8 == 0) bv = ~av;
      model(av, bv, ci, sb, es, ec);
      idle($urandom_range(0, 2), $sformatf("rand%0d", i));
      op(av, bv, ci, sb, es, ec, $urandom_range(0, NW), $sformatf("rand%0d", i));
    end

    idle(2, "tail");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
